// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array feed controller.
package feed_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feed_state_t;

  // Wide enough to hold every phase count (max DEPTH+DIM-2) without wrapping.
  function automatic int unsigned cnt_w(input int unsigned depth, input int unsigned dim);
    return $clog2(depth + dim);
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Host load port and fifo/array control outputs of the feed controller.
interface systolic_feed_ctrl_if #(
  parameter int unsigned DIM  = 8,
  parameter int unsigned BITS = 64
) ();

  logic                  start;
  logic                  load_valid;
  logic                  load_ready;
  logic [DIM*BITS-1:0]   load_data;
  logic [DIM-1:0]        fifo_en;
  logic [DIM*BITS-1:0]   fifo_d;
  logic                  sa_en;
  logic                  busy;
  logic                  done;

  modport master (
    output start, load_valid, load_data,
    input  load_ready, fifo_en, fifo_d, sa_en, busy, done
  );

  modport slave (
    input  start, load_valid, load_data,
    output load_ready, fifo_en, fifo_d, sa_en, busy, done
  );

endinterface

// File: rtl/systolic_feed_ctrl_skew_window_dec.sv
// Maps the FEED cycle count to the diagonal shift-enable mask: lane i is open for
// DEPTH cycles starting at t=i.
module skew_window_dec
  import feed_ctrl_pkg::*;
#(
  parameter int unsigned DIM   = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = cnt_w(DEPTH, DIM)
) (
  input  logic [CW-1:0]  i_t,
  output logic [DIM-1:0] o_mask
);

  logic [31:0] w_t;

  assign w_t = 32'(i_t);

  always_comb begin
    o_mask = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      o_mask[i] = (w_t >= i) && (w_t < i + DEPTH);
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Load/feed/drain sequencer for the delay fifos on one edge of the systolic array.
module systolic_feed_ctrl
  import feed_ctrl_pkg::*;
#(
  parameter int unsigned DIM   = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_feed_ctrl_if.slave  bus
);

  localparam int unsigned   CW        = cnt_w(DEPTH, DIM);
  localparam logic [CW-1:0] LastBeat  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LastFeed  = CW'(DEPTH + DIM - 2);
  localparam logic [CW-1:0] LastDrain = CW'(DIM - 1);

  feed_state_t     r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [DIM-1:0]  w_win;
  logic            w_beat;

  assign w_beat = (r_state == LOAD) && bus.load_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          if (r_cnt == LastBeat) begin
            w_state_nxt = FEED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      FEED: begin
        if (r_cnt == LastFeed) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == LastDrain) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  skew_window_dec #(
    .DIM   (DIM),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_skew_window_dec (
    .i_t    (r_cnt),
    .o_mask (w_win)
  );

  // Only the LOAD beat path is combinational from inputs; all else decodes from state.
  assign bus.load_ready = (r_state == LOAD);
  assign bus.fifo_en    = w_beat ? '1 : ((r_state == FEED) ? w_win : '0);
  assign bus.fifo_d     = w_beat ? bus.load_data : '0;
  assign bus.sa_en      = (r_state == FEED) || (r_state == DRAIN);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench: table vectors, corner sequences and randomized runs against a
// cycle-offset reference model; a second instance covers DIM=2, DEPTH=8.
module tb_systolic_feed_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned P = 4;
  localparam int unsigned B = 8;

  typedef struct {
    logic        st;
    logic        v;
    logic [31:0] d;
    logic [3:0]  en;
    logic        sa;
    logic        dn;
    logic        bz;
    logic        rdy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_seen = 0;

  // Reference model: 0 idle, 1 loading, 2 after last beat (k = cycles since it).
  int   m_phase = 0;
  int   m_beats = 0;
  int   m_k = 0;

  systolic_feed_ctrl_if #(.DIM(D), .BITS(B)) bus ();
  systolic_feed_ctrl_if #(.DIM(2), .BITS(B)) bus2 ();

  systolic_feed_ctrl #(.DIM(D), .DEPTH(P), .BITS(B)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  systolic_feed_ctrl #(.DIM(2), .DEPTH(8), .BITS(B)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] act_vec();
    return {bus.load_ready, bus.fifo_en, bus.fifo_d, bus.sa_en, bus.busy, bus.done};
  endfunction

  function automatic logic [39:0] model_out(input logic v, input logic [31:0] d);
    logic [3:0] en;
    int t;
    en = '0;
    if (m_phase == 1) return {1'b1, v ? 4'hF : 4'h0, v ? d : 32'h0, 1'b0, 1'b1, 1'b0};
    if (m_phase == 2) begin
      t = m_k - 1;
      if (m_k <= int'(P + D - 1))
        for (int i = 0; i < int'(D); i++) en[i] = (t >= i) && (t < i + int'(P));
      return {1'b0, en, 32'h0, m_k <= int'(P + 2 * D - 1), 1'b1, m_k == int'(P + 2 * D)};
    end
    return '0;
  endfunction

  task automatic model_step(input logic st, input logic v);
    case (m_phase)
      0: if (st) begin m_phase = 1; m_beats = 0; end
      1: if (v) begin
        m_beats++;
        if (m_beats == int'(P)) begin m_phase = 2; m_k = 1; end
      end
      default: if (m_k == int'(P + 2 * D)) m_phase = 0; else m_k++;
    endcase
  endtask

  // Called at posedge+1; checks this cycle at the negedge.
  task automatic cycle(input string nm, input logic st, input logic v, input logic [31:0] d);
    bus.start = st;
    bus.load_valid = v;
    bus.load_data = d;
    @(negedge clk);
    check(nm, act_vec(), model_out(v, d));
    @(posedge clk);
    model_step(st, v);
    #1;
  endtask

  task automatic run_table();
    vec_t tbl[$];
    logic [3:0] feed_en[7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [31:0] beats[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    tbl.push_back('{1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b1, beats[i], 4'hF, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int i = 0; i < 7; i++)
      tbl.push_back('{1'b0, 1'b0, 32'h0, feed_en[i], 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      bus.start = tbl[i].st;
      bus.load_valid = tbl[i].v;
      bus.load_data = tbl[i].d;
      @(negedge clk);
      check($sformatf("table[%0d]", i), act_vec(),
            {tbl[i].rdy, tbl[i].en, tbl[i].v ? tbl[i].d : 32'h0, tbl[i].sa, tbl[i].bz, tbl[i].dn});
      @(posedge clk);
      model_step(tbl[i].st, tbl[i].v);
      #1;
    end
  endtask

  task automatic finish_seq(input string nm);
    for (int i = 0; i < 200 && m_phase != 0; i++) cycle(nm, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [1:0] exp6[9] = '{2'h1, 2'h3, 2'h3, 2'h3, 2'h3, 2'h3, 2'h3, 2'h3, 2'h2};
    int d0;
    bus.start = 0; bus.load_valid = 0; bus.load_data = '0;
    bus2.start = 0; bus2.load_valid = 0; bus2.load_data = '0;

    // 1: reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", act_vec(), 40'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) cycle("idle_no_start", 1'b0, 1'b0, 32'h0);

    // 2: full sequence from table
    d0 = done_seen;
    run_table();
    check("single_done_seq", 40'(done_seen - d0), 40'd1);

    // 3: load stalls
    cycle("stall_start", 1'b1, 1'b0, 32'h0);
    begin
      logic vp[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) cycle("stall_beat", 1'b0, vp[i], $urandom);
    end
    check("stall_in_feed", 40'(m_phase), 40'd2);
    finish_seq("stall_tail");

    // 4: ignored inputs
    for (int i = 0; i < 3; i++) cycle("idle_valid_ignored", 1'b0, 1'b1, $urandom);
    d0 = done_seen;
    cycle("ign_start", 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle("ign_beat", 1'b0, 1'b1, $urandom);
    cycle("feed_start_ignored", 1'b0, 1'b0, 32'h0);
    cycle("feed_start_ignored", 1'b1, 1'b0, 32'h0);
    finish_seq("ign_tail");
    for (int i = 0; i < 3; i++) cycle("ign_post", 1'b0, 1'b0, 32'h0);
    check("single_done_ign", 40'(done_seen - d0), 40'd1);

    // 5: async reset mid-FEED at t=3
    d0 = done_seen;
    cycle("rst_start", 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle("rst_beat", 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) cycle("rst_feed", 1'b0, 1'b0, 32'h0);
    #2;
    check("pre_reset_t3", act_vec(), {1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_reset_now", act_vec(), 40'h0);
    m_phase = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", act_vec(), 40'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_reset_idle", 1'b0, 1'b0, 32'h0);
    check("no_done_on_reset", 40'(done_seen - d0), 40'd0);
    run_table();

    // Randomized sequences with stalls, spurious starts and stray valids
    for (int s = 0; s < 20; s++) begin
      cycle("rnd_start", 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 300 && m_phase != 0; i++)
        cycle("rnd", ($urandom_range(0, 3) == 0) && (m_phase != 2 || m_k < int'(P + 2 * D)),
              $urandom_range(0, 2) != 0, $urandom);
      check("rnd_returned_idle", 40'(m_phase), 40'd0);
      if ($urandom_range(0, 1) == 1) cycle("rnd_gap", 1'b0, $urandom_range(0, 1) == 1, $urandom);
    end

    // 6: DIM=2, DEPTH=8 instance
    bus2.start = 1'b1;
    @(negedge clk);
    check("p6_idle", 40'({bus2.busy, bus2.sa_en, bus2.fifo_en}), 40'h0);
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus2.load_valid = 1'b1;
      bus2.load_data = 16'(i + 1);
      @(negedge clk);
      check("p6_load", 40'({bus2.load_ready, bus2.fifo_en, bus2.fifo_d}),
            40'({1'b1, 2'h3, 16'(i + 1)}));
      @(posedge clk); #1;
    end
    bus2.load_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("p6_feed[%0d]", i), 40'({bus2.sa_en, bus2.fifo_en}), 40'({1'b1, exp6[i]}));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("p6_drain", 40'({bus2.sa_en, bus2.fifo_en, bus2.done}), 40'({1'b1, 2'h0, 1'b0}));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("p6_done", 40'({bus2.sa_en, bus2.busy, bus2.done}), 40'({1'b0, 1'b1, 1'b1}));
    @(posedge clk); #1;
    @(negedge clk);
    check("p6_back_idle", 40'({bus2.busy, bus2.done}), 40'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
